// File: rtl/ysyx_25040101_ifu_if.sv
// rtl/ysyx_25040101_ifu_if.sv - IFU bus bundle: AR/R fetch channel, IDU handoff, EXU next-PC, counters
interface ysyx_25040101_ifu_if;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i;
   logic        rready_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [1:0]  inst_err_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] npc_i;
   logic        npc_valid_i;
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;

   // IFU side
   modport master (
      output araddr_o, arvalid_o, rready_o,
      output inst_o, pc_o, inst_err_o, inst_valid_o,
      output fetch_cnt_o, stall_cnt_o,
      input  arready_i, rdata_i, rresp_i, rvalid_i,
      input  inst_ready_i, npc_i, npc_valid_i
   );

   // memory / IDU / EXU side
   modport slave (
      input  araddr_o, arvalid_o, rready_o,
      input  inst_o, pc_o, inst_err_o, inst_valid_o,
      input  fetch_cnt_o, stall_cnt_o,
      output arready_i, rdata_i, rresp_i, rvalid_i,
      output inst_ready_i, npc_i, npc_valid_i
   );
endinterface

// File: rtl/ysyx_25040101_ifu.sv
// rtl/ysyx_25040101_ifu.sv - multi-cycle RV32E instruction fetch unit owning the PC
module ysyx_25040101_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   ysyx_25040101_ifu_if.master       bus
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_RESP    = 2'd1,
      S_DELIV   = 2'd2,
      S_WAIT_PC = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] fetch_q, fetch_d;
   logic [31:0] stall_q, stall_d;
   logic        misaligned;

   // A PC that is not word aligned never reaches the bus; it is reported instead
   assign misaligned = (pc_q[1:0] != 2'b00);

   // State, PC, captured instruction and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= 32'h0;
         err_q   <= 2'b00;
         fetch_q <= 32'h0;
         stall_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         fetch_q <= fetch_d;
         stall_q <= stall_d;
      end
   end

   // Next-state logic; inputs outside their own state are simply not looked at
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      fetch_d = fetch_q;
      stall_d = stall_q;
      case (state_q)
         S_REQ: begin
            stall_d = stall_q + 32'd1;
            if (misaligned) begin
               inst_d  = 32'h0;
               err_d   = 2'b10;
               state_d = S_DELIV;
            end else if (bus.arready_i) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            stall_d = stall_q + 32'd1;
            if (bus.rvalid_i) begin
               inst_d  = bus.rdata_i;
               err_d   = (bus.rresp_i != 2'b00) ? 2'b01 : 2'b00;
               state_d = S_DELIV;
            end
         end
         S_DELIV: begin
            if (bus.inst_ready_i) begin
               fetch_d = fetch_q + 32'd1;
               state_d = S_WAIT_PC;
            end
         end
         S_WAIT_PC: begin
            if (bus.npc_valid_i) begin
               pc_d    = bus.npc_i;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Handshake outputs come from the registered state only; reset masks them immediately
   assign bus.arvalid_o    = !rst && (state_q == S_REQ) && !misaligned;
   assign bus.rready_o     = !rst && (state_q == S_RESP);
   assign bus.inst_valid_o = !rst && (state_q == S_DELIV);

   assign bus.araddr_o    = pc_q;
   assign bus.pc_o        = pc_q;
   assign bus.inst_o      = inst_q;
   assign bus.inst_err_o  = err_q;
   assign bus.fetch_cnt_o = fetch_q;
   assign bus.stall_cnt_o = stall_q;

endmodule

// File: doc/ysyx_25040101_ifu.md
# ysyx_25040101_ifu

Instruction fetch unit for the multi-cycle RV32E core. It owns the PC register and fetches one instruction word per architectural step over a simple AR/R read channel. It hands each word, with its PC and a fetch error code, to the decode stage through a valid/ready handshake, then waits for the execute stage to return the next PC. It is the producer end of the instruction stream that the control-unit decoder consumes.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `araddr_o`, output, 32: fetch address; always equals `pc_o`.
- `arvalid_o`, output, 1: read request valid.
- `arready_i`, input, 1: memory accepts the request.
- `rdata_i`, input, 32: instruction word returned by memory.
- `rresp_i`, input, 2: memory response; any value other than `2'b00` is an access fault.
- `rvalid_i`, input, 1: read data valid.
- `rready_o`, output, 1: IFU accepts read data.
- `inst_o`, output, 32: instruction word to IDU (`opcode` = `[6:0]`, `func3` = `[14:12]`, `func7` bit = `[30]`).
- `pc_o`, output, 32: PC of `inst_o`.
- `inst_err_o`, output, 2: fetch error code. `00` = ok, `01` = access fault, `10` = misaligned PC.
- `inst_valid_o`, output, 1: `inst_o`, `pc_o` and `inst_err_o` are valid.
- `inst_ready_i`, input, 1: IDU accepts the instruction.
- `npc_i`, input, 32: next PC from EXU.
- `npc_valid_i`, input, 1: `npc_i` is valid; single-cycle pulse.
- `fetch_cnt_o`, output, 32: number of instructions handed to IDU.
- `stall_cnt_o`, output, 32: number of cycles spent in `S_REQ` or `S_RESP`.

## Operation
- Four-state FSM: `S_REQ`, `S_RESP`, `S_DELIV`, `S_WAIT_PC`.
- **S_REQ**
  - If `pc[1:0] != 0`: no bus request; `inst_q <= 32'h0`, `err_q <= 2'b10`, go to `S_DELIV` next cycle.
  - Otherwise: `arvalid_o = 1`. On `arready_i`, go to `S_RESP`.
- **S_RESP**
  - `rready_o = 1`.
  - On `rvalid_i`: `inst_q <= rdata_i`; `err_q <= (rresp_i != 0) ? 2'b01 : 2'b00`; go to `S_DELIV`.
- **S_DELIV**
  - `inst_valid_o = 1`; `inst_o`, `pc_o` and `inst_err_o` are held stable until accepted.
  - On `inst_ready_i`: `fetch_cnt` increments and the FSM goes to `S_WAIT_PC`.
- **S_WAIT_PC**
  - On `npc_valid_i`: `pc <= npc_i`, go to `S_REQ`.
- `npc_valid_i` is ignored in every state except `S_WAIT_PC`.
- `rvalid_i` is ignored outside `S_RESP`; `rready_o` is 0 there.
- `arvalid_o`, once raised, stays high with a stable `araddr_o` until `arready_i`. It is never withdrawn.
- Counters:
  - Both are 32-bit and wrap from `32'hFFFF_FFFF` to 0.
  - `stall_cnt` increments on each non-reset cycle in `S_REQ` or `S_RESP`, including the handshake cycle.
- Memory is reset by the same `rst`. After reset, no R beat from a transaction issued before reset may arrive.

## Timing
- Reset, for any cycle with `rst = 1`:
  - `pc <= RESET_PC`, state `<= S_REQ`, `inst_q <= 0`, `err_q <= 0`, both counters `<= 0`.
  - `arvalid_o`, `rready_o` and `inst_valid_o` are forced to 0 in that cycle.
- The first request is visible in the first cycle after `rst` falls.
- Reset mid-operation, in any state, aborts the transaction. No partial instruction is delivered.
- Valid/ready outputs are decoded from the registered state only, with no combinational path from inputs to valid outputs.
  - `araddr_o` and `pc_o` are driven from the `pc` register.
  - `inst_o` and `inst_err_o` are driven from `inst_q` and `err_q`.
- Best case, with `arready`, `rvalid`, `inst_ready` and `npc_valid` each asserted on the first opportunity:
  - Request in cycle 0, R beat in cycle 1, `inst_valid_o` in cycle 2, `npc_valid_i` accepted in cycle 3.
  - The next request is in cycle 4, giving 4 cycles per instruction.
- Misaligned PC: `inst_valid_o` in the cycle after entering `S_REQ`, and no AR beat is issued.

## Test plan
- Reset with `RESET_PC = 32'h8000_0000`, all slaves ready immediately.
  - Required: `arvalid_o = 1` with `araddr_o = 32'h8000_0000` in the first post-reset cycle.
  - Return `rdata_i = 32'h0010_0093`: `inst_valid_o = 1` two cycles later, `inst_o = 32'h0010_0093`, `inst_err_o = 0`.
  - Then pulse `npc_i = 32'h8000_0004`: next `araddr_o = 32'h8000_0004`, and `fetch_cnt_o = 1`.
- Backpressure: hold `arready_i = 0` for 3 cycles, then `rvalid_i` late by 2 cycles, then `inst_ready_i` low for 4 cycles.
  - Required: `araddr_o` and `inst_o` remain stable throughout; exactly one AR beat; `stall_cnt_o = 7` (4 cycles in `S_REQ` + 3 in `S_RESP`).
- Access fault: `rresp_i = 2'b10` with `rdata_i = 32'hDEAD_BEEF`.
  - Required: `inst_err_o = 2'b01`, `inst_o = 32'hDEAD_BEEF`.
- Misaligned PC: `npc_i = 32'h8000_0002`.
  - Required: no `arvalid_o`; next cycle `inst_valid_o = 1`, `inst_err_o = 2'b10`, `inst_o = 0`, `pc_o = 32'h8000_0002`.
- Spurious inputs: pulse `npc_valid_i` during `S_RESP` and `S_DELIV`, and `rvalid_i` during `S_REQ`.
  - Required: `pc` unchanged and no state change.
- Mid-operation reset: assert `rst` for one cycle while in `S_DELIV`.
  - Required: `inst_valid_o = 0` in that cycle; next cycle `araddr_o = RESET_PC` with `arvalid_o = 1`; both counters are 0.
